ddr3_rw_arbiter: RTL and testbench

//  Schedules commands from the write-path command FIFO and the read-path command FIFO onto the single DDR3 controller command port.

---
 rtl/ddr3_rw_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rw_arbiter
// Brief    : Write/read command arbiter in front of a single DDR3 controller
//            command port. Multi-chunk bursts stay contiguous, same-direction
//            packets are batched. Optional fairness: RW_ARB_FAIRNESS_EN.
// Revision : 1.0  initial release
// ============================================================================
module ddr3_rw_arbiter #(
    parameter int ADDRS        = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int MAX_RUN      = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_store_i,
    output logic                    wr_accept_o,
    input  logic                    wr_wseq_i,
    input  logic [AXI_ID_WIDTH-1:0] wr_wrid_i,
    input  logic [ADDRS-1:0]        wr_addr_i,
    input  logic                    rd_fetch_i,
    output logic                    rd_accept_o,
    input  logic                    rd_rseq_i,
    input  logic [AXI_ID_WIDTH-1:0] rd_rdid_i,
    input  logic [ADDRS-1:0]        rd_addr_i,
    output logic                    ctl_req_o,
    input  logic                    ctl_run_i,
    output logic                    ctl_rdwr_o,
    output logic                    ctl_seq_o,
    output logic [AXI_ID_WIDTH-1:0] ctl_id_o,
    output logic [ADDRS-1:0]        ctl_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_lock;
    logic                    w_lock_nxt;
    logic                    r_req;
    logic                    r_rdwr;
    logic                    r_seq;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [ADDRS-1:0]        r_addr;

    logic w_empty;
    logic w_cur_rd;
    logic w_cur_v;
    logic w_cur_seq;
    logic w_oth_v;
    logic w_oth_seq;
    logic w_switch;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_run_restart;
    logic w_run_step;

    assign w_empty   = !r_req || ctl_run_i;
    assign w_cur_rd  = (r_state == ST_READ);
    assign w_cur_v   = w_cur_rd ? rd_fetch_i : wr_store_i;
    assign w_cur_seq = w_cur_rd ? rd_rseq_i  : wr_wseq_i;
    assign w_oth_v   = w_cur_rd ? wr_store_i : rd_fetch_i;
    assign w_oth_seq = w_cur_rd ? wr_wseq_i  : rd_rseq_i;

`ifdef RW_ARB_FAIRNESS_EN
    localparam int c_RUN_W = ($clog2(MAX_RUN + 1) > 4) ? $clog2(MAX_RUN + 1) : 4;
    localparam logic [c_RUN_W-1:0] c_MAX_RUN = c_RUN_W'(MAX_RUN);

    logic [c_RUN_W-1:0] r_run_cnt;

    assign w_switch = w_oth_v && (!w_cur_v || (r_run_cnt >= c_MAX_RUN));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run_cnt <= '0;
        end else if (w_run_restart) begin
            r_run_cnt <= c_RUN_W'(1);
        end else if (w_run_step && (r_run_cnt < c_MAX_RUN)) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end
`else
    logic w_unused_run;

    assign w_switch     = w_oth_v && !w_cur_v;
    assign w_unused_run = (MAX_RUN != 0) ^ w_run_restart ^ w_run_step;
`endif

    // Grants only when the output register is free; a continuation chunk of
    // the current direction always wins, a locked empty head stalls.
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_nxt    = r_lock;
        w_grant_wr    = 1'b0;
        w_grant_rd    = 1'b0;
        w_run_restart = 1'b0;
        w_run_step    = 1'b0;
        if (reset_n && w_empty) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_lock_nxt = 1'b0;
                    if (rd_fetch_i) begin
                        w_grant_rd    = 1'b1;
                        w_state_nxt   = ST_READ;
                        w_lock_nxt    = rd_rseq_i;
                        w_run_restart = 1'b1;
                    end else if (wr_store_i) begin
                        w_grant_wr    = 1'b1;
                        w_state_nxt   = ST_WRITE;
                        w_lock_nxt    = wr_wseq_i;
                        w_run_restart = 1'b1;
                    end
                end
                default: begin
                    if (w_cur_v && w_cur_seq) begin
                        w_grant_rd = w_cur_rd;
                        w_grant_wr = !w_cur_rd;
                        w_lock_nxt = 1'b1;
                    end else if (!w_cur_v && !w_oth_v) begin
                        w_state_nxt = ST_IDLE;
                        w_lock_nxt  = 1'b0;
                    end else if (!w_cur_v && r_lock) begin
                        w_lock_nxt = 1'b1;
                    end else if (w_switch) begin
                        w_grant_rd    = !w_cur_rd;
                        w_grant_wr    = w_cur_rd;
                        w_state_nxt   = w_cur_rd ? ST_WRITE : ST_READ;
                        w_lock_nxt    = w_oth_seq;
                        w_run_restart = 1'b1;
                    end else if (w_cur_v) begin
                        w_grant_rd = w_cur_rd;
                        w_grant_wr = !w_cur_rd;
                        w_lock_nxt = 1'b0;
                        w_run_step = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req  <= 1'b0;
            r_rdwr <= 1'b0;
            r_seq  <= 1'b0;
            r_id   <= '0;
            r_addr <= '0;
        end else if (w_grant_rd) begin
            r_req  <= 1'b1;
            r_rdwr <= 1'b1;
            r_seq  <= rd_rseq_i;
            r_id   <= rd_rdid_i;
            r_addr <= rd_addr_i;
        end else if (w_grant_wr) begin
            r_req  <= 1'b1;
            r_rdwr <= 1'b0;
            r_seq  <= wr_wseq_i;
            r_id   <= wr_wrid_i;
            r_addr <= wr_addr_i;
        end else if (ctl_run_i) begin
            r_req  <= 1'b0;
        end
    end

    assign wr_accept_o = w_grant_wr;
    assign rd_accept_o = w_grant_rd;
    assign ctl_req_o   = r_req;
    assign ctl_rdwr_o  = r_rdwr;
    assign ctl_seq_o   = r_seq;
    assign ctl_id_o    = r_id;
    assign ctl_addr_o  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_rw_arbiter
// Brief    : Directed bench for ddr3_rw_arbiter with FIFO models and an
//            expected-order scoreboard of controller commands.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_rw_arbiter;

    localparam int ADDRS = 32;
    localparam int IDW   = 4;

    typedef struct packed {
        logic            rdwr;
        logic            seq;
        logic [IDW-1:0]  id;
        logic [ADDRS-1:0] addr;
    } cmd_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             wr_store_i, wr_accept_o, wr_wseq_i;
    logic [IDW-1:0]   wr_wrid_i;
    logic [ADDRS-1:0] wr_addr_i;
    logic             rd_fetch_i, rd_accept_o, rd_rseq_i;
    logic [IDW-1:0]   rd_rdid_i;
    logic [ADDRS-1:0] rd_addr_i;
    logic             ctl_req_o, ctl_run_i, ctl_rdwr_o, ctl_seq_o;
    logic [IDW-1:0]   ctl_id_o;
    logic [ADDRS-1:0] ctl_addr_o;

    always #5 clock = ~clock;

    ddr3_rw_arbiter #(.ADDRS(ADDRS), .AXI_ID_WIDTH(IDW), .MAX_RUN(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_store_i(wr_store_i), .wr_accept_o(wr_accept_o), .wr_wseq_i(wr_wseq_i),
        .wr_wrid_i(wr_wrid_i), .wr_addr_i(wr_addr_i),
        .rd_fetch_i(rd_fetch_i), .rd_accept_o(rd_accept_o), .rd_rseq_i(rd_rseq_i),
        .rd_rdid_i(rd_rdid_i), .rd_addr_i(rd_addr_i),
        .ctl_req_o(ctl_req_o), .ctl_run_i(ctl_run_i), .ctl_rdwr_o(ctl_rdwr_o),
        .ctl_seq_o(ctl_seq_o), .ctl_id_o(ctl_id_o), .ctl_addr_o(ctl_addr_o)
    );

    cmd_t wq[$];
    cmd_t rq[$];
    cmd_t exp_q[$];
    logic w_hold = 1'b0;
    logic hold_v = 1'b0;
    cmd_t hold_c;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic cmd_t mk(input logic rdwr, input logic seq, input int id, input int addr);
        cmd_t c;
        c.rdwr = rdwr;
        c.seq  = seq;
        c.id   = IDW'(id);
        c.addr = ADDRS'(addr);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_heads();
        wr_store_i = (wq.size() != 0) && !w_hold;
        wr_wseq_i  = (wq.size() != 0) ? wq[0].seq  : 1'b0;
        wr_wrid_i  = (wq.size() != 0) ? wq[0].id   : '0;
        wr_addr_i  = (wq.size() != 0) ? wq[0].addr : '0;
        rd_fetch_i = (rq.size() != 0);
        rd_rseq_i  = (rq.size() != 0) ? rq[0].seq  : 1'b0;
        rd_rdid_i  = (rq.size() != 0) ? rq[0].id   : '0;
        rd_addr_i  = (rq.size() != 0) ? rq[0].addr : '0;
        #1;
    endtask

    // One clock: observe at negedge, pop the bench FIFOs after the posedge.
    task automatic cyc();
        cmd_t obs;
        logic pw;
        logic pr;
        pw = 1'b0;
        pr = 1'b0;
        @(negedge clock);
        if (reset_n) begin
            obs.rdwr = ctl_rdwr_o;
            obs.seq  = ctl_seq_o;
            obs.id   = ctl_id_o;
            obs.addr = ctl_addr_o;
            chk("accept_excl", {63'd0, wr_accept_o & rd_accept_o}, 64'd0);
            if (hold_v) begin
                chk("hold_req", {63'd0, ctl_req_o}, 64'd1);
                chk("hold_fields", {26'd0, obs}, {26'd0, hold_c});
            end
            if (ctl_req_o && ctl_run_i) begin
                chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) chk("cmd_order", {26'd0, obs}, {26'd0, exp_q.pop_front()});
            end
            hold_v = ctl_req_o && !ctl_run_i;
            hold_c = obs;
            pw = wr_accept_o;
            pr = rd_accept_o;
        end
        @(posedge clock);
        #1;
        if (pw) wq.delete(0);
        if (pr) rq.delete(0);
        drive_heads();
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cyc();
            k++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        ctl_run_i = 1'b0;
        wq.push_back(mk(0, 0, 1, 'h080));
        drive_heads();
        @(negedge clock);
        chk("rst_req",    {63'd0, ctl_req_o},   64'd0);
        chk("rst_rdwr",   {63'd0, ctl_rdwr_o},  64'd0);
        chk("rst_seq",    {63'd0, ctl_seq_o},   64'd0);
        chk("rst_id",     64'(ctl_id_o),        64'd0);
        chk("rst_addr",   64'(ctl_addr_o),      64'd0);
        chk("rst_wr_acc", {63'd0, wr_accept_o}, 64'd0);
        chk("rst_rd_acc", {63'd0, rd_accept_o}, 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        cyc();
        chk("pre_rst_req",  {63'd0, ctl_req_o}, 64'd1);
        chk("pre_rst_addr", 64'(ctl_addr_o),    64'h080);
        wq.push_back(mk(0, 0, 2, 'h100));
        drive_heads();
        cyc();
        #2 reset_n = 1'b0;
        hold_v = 1'b0;
        #1;
        chk("mid_rst_req",  {63'd0, ctl_req_o},   64'd0);
        chk("mid_rst_addr", 64'(ctl_addr_o),      64'd0);
        chk("mid_rst_acc",  {63'd0, wr_accept_o}, 64'd0);
        ctl_run_i = 1'b1;
        exp_q.push_back(mk(0, 0, 2, 'h100));
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("lat_accept",     {63'd0, wr_accept_o}, 64'd1);
        chk("lat_req_before", {63'd0, ctl_req_o},   64'd0);
        cyc();
        chk("lat_req_after",  {63'd0, ctl_req_o},   64'd1);
        chk("lat_addr",       64'(ctl_addr_o),      64'h100);
        wait_drain(10);

        // Two-chunk write burst, back to back.
        wq.push_back(mk(0, 0, 3, 'h000));
        wq.push_back(mk(0, 1, 3, 'h010));
        exp_q.push_back(mk(0, 0, 3, 'h000));
        exp_q.push_back(mk(0, 1, 3, 'h010));
        drive_heads();
        cyc();
        chk("w2_c0_req", {63'd0, ctl_req_o}, 64'd1);
        chk("w2_c0_seq", {63'd0, ctl_seq_o}, 64'd0);
        cyc();
        chk("w2_c1_req",  {63'd0, ctl_req_o},  64'd1);
        chk("w2_c1_seq",  {63'd0, ctl_seq_o},  64'd1);
        chk("w2_c1_rdwr", {63'd0, ctl_rdwr_o}, 64'd0);
        wait_drain(10);

        // Simultaneous arrival from idle: read wins.
        wq.push_back(mk(0, 0, 4, 'h400));
        rq.push_back(mk(1, 0, 5, 'h500));
        exp_q.push_back(mk(1, 0, 5, 'h500));
        exp_q.push_back(mk(0, 0, 4, 'h400));
        drive_heads();
        chk("sim_rd_first", {63'd0, rd_accept_o}, 64'd1);
        chk("sim_no_wr",    {63'd0, wr_accept_o}, 64'd0);
        wait_drain(20);

        // Four-chunk write burst with a head gap; read waits for the burst.
        wq.push_back(mk(0, 0, 6, 'h600));
        wq.push_back(mk(0, 1, 6, 'h610));
        wq.push_back(mk(0, 1, 6, 'h620));
        wq.push_back(mk(0, 1, 6, 'h630));
        wq.push_back(mk(0, 0, 7, 'h640));
        exp_q.push_back(mk(0, 0, 6, 'h600));
        exp_q.push_back(mk(0, 1, 6, 'h610));
        exp_q.push_back(mk(0, 1, 6, 'h620));
        exp_q.push_back(mk(0, 1, 6, 'h630));
        exp_q.push_back(mk(0, 0, 7, 'h640));
        exp_q.push_back(mk(1, 0, 8, 'h700));
        drive_heads();
        cyc();
        rq.push_back(mk(1, 0, 8, 'h700));
        drive_heads();
        cyc();
        w_hold = 1'b1;
        drive_heads();
        for (int i = 0; i < 3; i++) begin
            chk("burst_no_rd", {63'd0, rd_accept_o}, 64'd0);
            cyc();
        end
        w_hold = 1'b0;
        drive_heads();
        wait_drain(40);

        // Five single-chunk writes with one read queued after the first.
        for (int i = 0; i < 5; i++) wq.push_back(mk(0, 0, 9, 'h800 + 16 * i));
`ifdef RW_ARB_FAIRNESS_EN
        exp_q.push_back(mk(0, 0, 9, 'h800));
        exp_q.push_back(mk(0, 0, 9, 'h810));
        exp_q.push_back(mk(1, 0, 10, 'h900));
        exp_q.push_back(mk(0, 0, 9, 'h820));
        exp_q.push_back(mk(0, 0, 9, 'h830));
        exp_q.push_back(mk(0, 0, 9, 'h840));
`else
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(0, 0, 9, 'h800 + 16 * i));
        exp_q.push_back(mk(1, 0, 10, 'h900));
`endif
        drive_heads();
        cyc();
        rq.push_back(mk(1, 0, 10, 'h900));
        drive_heads();
        wait_drain(40);

        // Controller backpressure.
        ctl_run_i = 1'b0;
        wq.push_back(mk(0, 0, 11, 'hA00));
        wq.push_back(mk(0, 0, 12, 'hA10));
        exp_q.push_back(mk(0, 0, 11, 'hA00));
        exp_q.push_back(mk(0, 0, 12, 'hA10));
        drive_heads();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_req",  {63'd0, ctl_req_o},   64'd1);
            chk("bp_addr", 64'(ctl_addr_o),      64'hA00);
            chk("bp_acc",  {63'd0, wr_accept_o}, 64'd0);
            cyc();
        end
        ctl_run_i = 1'b1;
        #1;
        chk("bp_reload", {63'd0, wr_accept_o}, 64'd1);
        wait_drain(10);
        cyc();
        cyc();
        chk("idle_req", {63'd0, ctl_req_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
